// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: redirect requests in, fetch address and enable out.
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [5:0]        stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_address_i;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              pc_misaligned;

    modport master (
        output stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        input  pc, ce, pc_misaligned
    );

    modport slave (
        input  stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        output pc, ce, pc_misaligned
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: flush > stall-hold > live branch > pending branch > sequential.
// A branch raised while fetch is stalled is parked and applied when the stall lifts.
module pc_gen #(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int unsigned       STEP         = 4,
    parameter int unsigned       ALIGN_BITS   = 2
) (
    input logic       Clk,
    input logic       Rst,
    pc_gen_if.slave   bus
);
    localparam logic [ADDR_W-1:0] StepW     = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              pc_misaligned_q, pc_misaligned_d;

    // Only the fetch stall bit matters to this stage.
    logic unused_stall;
    assign unused_stall = ^bus.stall[5:1];

    always_comb begin
        pc_d          = pc_q;
        ce_d          = ce_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        if (!ce_q) begin
            ce_d = 1'b1;
            pc_d = RESET_VECTOR;
        end else if (bus.flush) begin
            pc_d         = bus.new_pc;
            pend_valid_d = 1'b0;
        end else if (bus.stall[0]) begin
            if (bus.branch_flag_i) begin
                pend_valid_d  = 1'b1;
                pend_target_d = bus.branch_target_address_i;
            end
        end else if (bus.branch_flag_i) begin
            pc_d         = bus.branch_target_address_i;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
        end else begin
            pc_d = pc_q + StepW;
        end

        // AlignMask is zero when ALIGN_BITS is zero, which ties the flag low.
        pc_misaligned_d = |(pc_d & AlignMask);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q            <= RESET_VECTOR;
            ce_q            <= 1'b0;
            pend_valid_q    <= 1'b0;
            pend_target_q   <= '0;
            pc_misaligned_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ce_q            <= ce_d;
            pend_valid_q    <= pend_valid_d;
            pend_target_q   <= pend_target_d;
            pc_misaligned_q <= pc_misaligned_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.ce            = ce_q;
    assign bus.pc_misaligned = pc_misaligned_q;
endmodule

// File: tb/tb_pc_gen.sv
// Drives three pc_gen configurations (default, 8-bit wrap, MIPS reset vector) from shared
// stimulus and compares each against a behavioural model, with directed and random phases.
module tb_pc_gen;
    logic        Clk;
    logic        Rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br;
    logic [31:0] bt;

    int unsigned n_checks;
    int unsigned n_pass;

    pc_gen_if #(.ADDR_W(32)) if0 ();
    pc_gen_if #(.ADDR_W(8))  if1 ();
    pc_gen_if #(.ADDR_W(32)) if2 ();

    assign if0.stall = stall;
    assign if0.flush = flush;
    assign if0.new_pc = new_pc;
    assign if0.branch_flag_i = br;
    assign if0.branch_target_address_i = bt;
    assign if1.stall = stall;
    assign if1.flush = flush;
    assign if1.new_pc = new_pc[7:0];
    assign if1.branch_flag_i = br;
    assign if1.branch_target_address_i = bt[7:0];
    assign if2.stall = stall;
    assign if2.flush = flush;
    assign if2.new_pc = new_pc;
    assign if2.branch_flag_i = br;
    assign if2.branch_target_address_i = bt;

    pc_gen #(.ADDR_W(32)) dut0 (.Clk(Clk), .Rst(Rst), .bus(if0));
    pc_gen #(.ADDR_W(8))  dut1 (.Clk(Clk), .Rst(Rst), .bus(if1));
    pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'hBFC0_0000)) dut2 (.Clk(Clk), .Rst(Rst), .bus(if2));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference state per configuration
    logic [31:0] m_pc[3];
    logic        m_ce[3];
    logic        m_pv[3];
    logic [31:0] m_pt[3];
    logic        m_mis[3];
    logic [31:0] m_mask[3];
    logic [31:0] m_rv[3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (Rst) begin
                m_ce[i] = 1'b0; m_pc[i] = m_rv[i]; m_pv[i] = 1'b0; m_pt[i] = '0;
            end else if (!m_ce[i]) begin
                m_ce[i] = 1'b1;
            end else if (flush) begin
                m_pc[i] = new_pc & m_mask[i]; m_pv[i] = 1'b0;
            end else if (stall[0]) begin
                if (br) begin m_pv[i] = 1'b1; m_pt[i] = bt & m_mask[i]; end
            end else if (br) begin
                m_pc[i] = bt & m_mask[i]; m_pv[i] = 1'b0;
            end else if (m_pv[i]) begin
                m_pc[i] = m_pt[i]; m_pv[i] = 1'b0;
            end else begin
                m_pc[i] = (m_pc[i] + 32'd4) & m_mask[i];
            end
            m_mis[i] = Rst ? 1'b0 : (m_pc[i][1:0] != 2'b00);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        check_val("pc0", if0.pc, m_pc[0]);
        check_val("ce0", {31'd0, if0.ce}, {31'd0, m_ce[0]});
        check_val("mis0", {31'd0, if0.pc_misaligned}, {31'd0, m_mis[0]});
        check_val("pc1", {24'd0, if1.pc}, m_pc[1]);
        check_val("ce1", {31'd0, if1.ce}, {31'd0, m_ce[1]});
        check_val("mis1", {31'd0, if1.pc_misaligned}, {31'd0, m_mis[1]});
        check_val("pc2", if2.pc, m_pc[2]);
        check_val("ce2", {31'd0, if2.ce}, {31'd0, m_ce[2]});
        check_val("mis2", {31'd0, if2.pc_misaligned}, {31'd0, m_mis[2]});
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        m_mask[0] = 32'hFFFF_FFFF; m_mask[1] = 32'h0000_00FF; m_mask[2] = 32'hFFFF_FFFF;
        m_rv[0] = 32'h0; m_rv[1] = 32'h0; m_rv[2] = 32'hBFC0_0000;
        for (int i = 0; i < 3; i++) begin
            m_pc[i] = '0; m_ce[i] = 1'b0; m_pv[i] = 1'b0; m_pt[i] = '0; m_mis[i] = 1'b0;
        end
        Rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0; br = 1'b0; bt = '0;

        // Reset and startup
        repeat (3) begin
            tick();
            check_val("rst_pc", if0.pc, 32'h0);
            check_val("rst_ce", {31'd0, if0.ce}, 32'd0);
        end
        Rst = 1'b0;
        tick();
        check_val("start_ce", {31'd0, if0.ce}, 32'd1);
        check_val("start_pc", if0.pc, 32'h0);
        check_val("start_pc_rv", if2.pc, 32'hBFC0_0000);
        tick(); check_val("seq_4", if0.pc, 32'd4);
        tick(); check_val("seq_8", if0.pc, 32'd8);
        tick(); check_val("seq_12", if0.pc, 32'd12);

        // Wrap on the 8-bit instance
        flush = 1'b1; new_pc = 32'hFC;
        tick(); check_val("wrap_fc", {24'd0, if1.pc}, 32'hFC);
        flush = 1'b0;
        tick(); check_val("wrap_00", {24'd0, if1.pc}, 32'h00);
        tick(); check_val("wrap_04", {24'd0, if1.pc}, 32'h04);
        check_val("nowrap_104", if0.pc, 32'h104);

        // Pending branch across a 3-cycle stall
        stall = 6'b000001;
        tick(); check_val("stall_hold1", if0.pc, 32'h104);
        br = 1'b1; bt = 32'h100;
        tick(); check_val("stall_hold2", if0.pc, 32'h104);
        br = 1'b0;
        tick(); check_val("stall_hold3", if0.pc, 32'h104);
        stall = '0;
        tick(); check_val("pend_apply", if0.pc, 32'h100);
        tick(); check_val("pend_next", if0.pc, 32'h104);

        // Flush beats a pending branch
        stall = 6'b000001; br = 1'b1; bt = 32'h200;
        tick();
        br = 1'b0; flush = 1'b1; new_pc = 32'h180;
        tick(); check_val("flush_pc", if0.pc, 32'h180);
        flush = 1'b0;
        tick(); check_val("flush_hold", if0.pc, 32'h180);
        stall = '0;
        tick(); check_val("flush_clr", if0.pc, 32'h184);

        // Misalignment flag
        br = 1'b1; bt = 32'h102;
        tick();
        check_val("mis_pc", if0.pc, 32'h102);
        check_val("mis_set", {31'd0, if0.pc_misaligned}, 32'd1);
        br = 1'b0; flush = 1'b1; new_pc = 32'h300;
        tick(); check_val("mis_clr", {31'd0, if0.pc_misaligned}, 32'd0);
        flush = 1'b0;

        // Reset while stalled with a pending branch
        stall = 6'b000001; br = 1'b1; bt = 32'h400;
        tick();
        br = 1'b0; Rst = 1'b1;
        tick();
        check_val("mid_rst_pc", if2.pc, 32'hBFC0_0000);
        check_val("mid_rst_ce", {31'd0, if2.ce}, 32'd0);
        Rst = 1'b0; stall = '0;
        tick();
        check_val("mid_rel_pc", if2.pc, 32'hBFC0_0000);
        check_val("mid_rel_ce", {31'd0, if2.ce}, 32'd1);
        tick(); check_val("mid_seq", if2.pc, 32'hBFC0_0004);

        // Random phase
        for (int n = 0; n < 500; n++) begin
            Rst    = ($urandom_range(0, 49) == 0);
            stall  = 6'($urandom) & 6'b111110;
            stall[0] = ($urandom_range(0, 9) < 4);
            flush  = ($urandom_range(0, 9) == 0);
            new_pc = $urandom & 32'hFFFF_FFFC;
            br     = ($urandom_range(0, 3) == 0);
            bt     = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) bt = bt | 32'(2 * $urandom_range(0, 1) + 1);
            if ($urandom_range(0, 15) == 0) new_pc = new_pc | 32'h2;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage, successor to the fixed 32-bit PC register. It produces the fetch address and instruction-memory chip enable. It adds:
- exception/flush redirect with top priority;
- a pending-branch register, so a redirect raised while fetch is stalled is not lost;
- a configurable reset vector and step;
- a registered misalignment flag for the exception logic.

## Interface
Parameters:
- ADDR_W, 32, width of pc and all target addresses
- RESET_VECTOR, 0, pc value held during reset and until the first fetch
- STEP, 4, sequential increment in bytes
- ALIGN_BITS, 2, number of pc LSBs that must be zero for an aligned fetch

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset; synchronous, active-high (`RstEnable = 1'b1)
- stall  in  6  pipeline stall vector; only stall[0] (fetch) is used, 1 = hold pc
- flush  in  1  exception/eret redirect request
- new_pc  in  ADDR_W  flush target, valid when flush=1
- branch_flag_i  in  1  branch/jump taken from decode (`Branch = 1)
- branch_target_address_i  in  ADDR_W  branch target
- pc  out  ADDR_W  current fetch address (registered)
- ce  out  1  instruction-memory enable (registered), `ChipEnable = 1
- pc_misaligned  out  1  registered; 1 while pc[ALIGN_BITS-1:0] != 0

## Operation
- State: pc, ce, pend_valid, pend_target[ADDR_W-1:0], pc_misaligned.
- Rst=1 (any cycle, overrides everything):
  - ce<=0, pc<=RESET_VECTOR, pend_valid<=0, pend_target<=0, pc_misaligned<=0.
- ce=0 and Rst=0:
  - ce<=1; pc stays RESET_VECTOR.
  - All redirect inputs are ignored; pending stays clear.
- ce=1: next pc is chosen in strict priority order:
  1. flush=1: pc<=new_pc, pend_valid<=0. Applies even when stall[0]=1.
  2. stall[0]=1:
     - pc holds.
     - If branch_flag_i=1: pend_valid<=1, pend_target<=branch_target_address_i. The latest branch during a stall overwrites any earlier one.
  3. stall[0]=0, branch_flag_i=1: pc<=branch_target_address_i, pend_valid<=0. The live branch supersedes the pending one.
  4. stall[0]=0, pend_valid=1: pc<=pend_target, pend_valid<=0.
  5. Otherwise: pc<=pc+STEP, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
- pc_misaligned is recomputed from the value loaded into pc on every cycle in which pc updates.
  - Targets are loaded unmodified; the exception logic acts on the flag.
  - With ALIGN_BITS=0 the flag is tied to 0.
- RESET_VECTOR must be aligned; misaligned values are a configuration error.

## Timing
- Every output is registered; no combinational input-to-output path.
- Reset → fetch sequence:
  - Rst deasserted before edge N: ce=1 after edge N, pc=RESET_VECTOR.
  - First increment at edge N+1, if not stalled.
- Redirect latency:
  - A flush or unstalled branch sampled at edge K is visible on pc after edge K.
  - A pending branch is applied at the first edge with stall[0]=0, one cycle after the stall ends.
- A stall held for any number of cycles keeps pc and ce constant, unless flush=1.
- Simultaneous events:
  - flush + branch_flag_i: flush wins; the branch is dropped.
  - Rst + anything: reset wins.
- Reset during a stall with a pending branch: the pending branch is discarded; pc = RESET_VECTOR.

## Test plan
- Reset/startup:
  - Stimulus: Rst=1 for 3 cycles, then 0; defaults.
  - Required: ce=0 and pc=0 during reset; ce=1 and pc=0 after the first post-reset edge; then pc=4, 8, 12 on successive edges.
- Wrap:
  - Stimulus: ADDR_W=8, flush to new_pc=8'hFC, then run unstalled.
  - Required: pc=FC, then 00, then 04.
- Pending branch:
  - Stimulus: stall[0]=1 for 3 cycles; branch_flag_i pulsed in the 2nd stall cycle with target 0x100; then release the stall.
  - Required: pc frozen during the stall; pc=0x100 after the first unstalled edge; pc=0x104 on the next edge.
- Flush priority:
  - Stimulus: stall[0]=1 with a branch to 0x200 pending; then flush=1, new_pc=0x180.
  - Required: pc=0x180 immediately; pending cleared; after the stall releases, pc=0x184 (not 0x200).
- Misalignment:
  - Stimulus: unstalled branch to 0x102.
  - Required: pc=0x102 and pc_misaligned=1 on the same edge; a subsequent flush to 0x300 clears the flag.
- Reset mid-operation:
  - Stimulus: Rst asserted for one cycle while stalled with a branch pending; RESET_VECTOR=0xBFC00000.
  - Required: pc=0xBFC00000, ce=0, pending cleared; after release, the fetch sequence is 0xBFC00000, then 0xBFC00004.
